// File: rtl/sram_pkg.sv
// -----------------------------------------------------------------------------
// sram_pkg
//   Shared types and helpers for the parametrised two-port SRAM model.
//   - state_e            : controller states (clear sweep, normal operation)
//   - COLLIDE_*          : encodings of the cross-port same-address policy
//   - merge_bytes()      : byte-enable merge of a new word into an old word
// -----------------------------------------------------------------------------
package sram_pkg;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } state_e;

  localparam int COLLIDE_READ_FIRST  = 0;
  localparam int COLLIDE_WRITE_FIRST = 1;

  // The merge helper works on a fixed maximum width so it can live in the
  // package; callers zero-extend their operands and truncate the result.
  localparam int MERGE_MAX_W      = 1024;
  localparam int MERGE_MAX_MASK_W = MERGE_MAX_W / 8;

  function automatic logic [MERGE_MAX_W-1:0] merge_bytes(
    input logic [MERGE_MAX_W-1:0]      old_word,
    input logic [MERGE_MAX_W-1:0]      new_word,
    input logic [MERGE_MAX_MASK_W-1:0] mask
  );
    logic [MERGE_MAX_W-1:0] res;
    res = old_word;
    for (int k = 0; k < MERGE_MAX_MASK_W; k++) begin
      if (mask[k]) res[8*k +: 8] = new_word[8*k +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/sram_rd_pipe.sv
// -----------------------------------------------------------------------------
// sram_rd_pipe
//   Read-return pipeline for one SRAM port. A request sampled on an edge
//   appears on rdata/rvalid after that edge (RD_LAT=1) or after the next one
//   (RD_LAT=2). rdata holds its last value between reads; reset clears both
//   rdata and rvalid and drops anything in flight.
// Ports
//   clock, reset   : clock and synchronous active-high reset
//   req_vld        : a read was accepted on this edge
//   req_data       : word returned by the array for that read
//   rdata, rvalid  : registered read data and one-cycle valid strobe
// -----------------------------------------------------------------------------
module sram_rd_pipe #(
  parameter int WIDTH  = 32,
  parameter int RD_LAT = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_vld,
  input  logic [WIDTH-1:0] req_data,
  output logic [WIDTH-1:0] rdata,
  output logic             rvalid
);

  // Stage p0: capture of the array word
  logic             vld_p0_q, vld_p0_d;
  logic [WIDTH-1:0] data_p0_q, data_p0_d;

  always_comb begin
    vld_p0_d  = req_vld;
    data_p0_d = req_vld ? req_data : data_p0_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      vld_p0_q  <= 1'b0;
      data_p0_q <= '0;
    end else begin
      vld_p0_q  <= vld_p0_d;
      data_p0_q <= data_p0_d;
    end
  end

  if (RD_LAT == 2) begin : g_lat2
    // Stage p1: optional output register
    logic             vld_p1_q, vld_p1_d;
    logic [WIDTH-1:0] data_p1_q, data_p1_d;

    always_comb begin
      vld_p1_d  = vld_p0_q;
      data_p1_d = vld_p0_q ? data_p0_q : data_p1_q;
    end

    always_ff @(posedge clock) begin
      if (reset) begin
        vld_p1_q  <= 1'b0;
        data_p1_q <= '0;
      end else begin
        vld_p1_q  <= vld_p1_d;
        data_p1_q <= data_p1_d;
      end
    end

    assign rdata  = data_p1_q;
    assign rvalid = vld_p1_q;
  end else begin : g_lat1
    assign rdata  = data_p0_q;
    assign rvalid = vld_p0_q;
  end

endmodule

// File: rtl/sram_2rw_param.sv
// -----------------------------------------------------------------------------
// sram_2rw_param
//   Single-clock two-port read/write SRAM model with byte write masks,
//   1- or 2-cycle read latency, defined same-address collision behaviour and
//   an optional zero-clear sweep after reset.
// Ports
//   clock, reset        : clock, synchronous active-high reset
//   ready               : requests are accepted while high
//   pN_en / pN_we       : request strobe / 1 = write, 0 = read   (N = 1, 2)
//   pN_addr             : word address (addresses >= DEPTH read 0, drop writes)
//   pN_wmask            : byte enables, bit k covers wdata[8k+7:8k]
//   pN_wdata            : write data
//   pN_rdata, pN_rvalid : read data (held between reads) and valid pulse
// -----------------------------------------------------------------------------
module sram_2rw_param
  import sram_pkg::*;
#(
  parameter  int WIDTH        = 32,
  parameter  int DEPTH        = 32,
  parameter  int RD_LAT       = 1,
  parameter  int COLLIDE_MODE = 0,
  parameter  int INIT_ZERO    = 1,
  localparam int ADDR_W       = $clog2(DEPTH),
  localparam int MASK_W       = WIDTH / 8
) (
  input  logic              clock,
  input  logic              reset,
  output logic              ready,
  input  logic              p1_en,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [MASK_W-1:0] p1_wmask,
  input  logic [WIDTH-1:0]  p1_wdata,
  output logic [WIDTH-1:0]  p1_rdata,
  output logic              p1_rvalid,
  input  logic              p2_en,
  input  logic              p2_we,
  input  logic [ADDR_W-1:0] p2_addr,
  input  logic [MASK_W-1:0] p2_wmask,
  input  logic [WIDTH-1:0]  p2_wdata,
  output logic [WIDTH-1:0]  p2_rdata,
  output logic              p2_rvalid
);

  if ((WIDTH % 8) != 0 || WIDTH < 8 || WIDTH > MERGE_MAX_W) begin : g_bad_width
    $error("sram_2rw_param: WIDTH must be a multiple of 8 in 8..%0d", MERGE_MAX_W);
  end
  if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_lat
    $error("sram_2rw_param: RD_LAT must be 1 or 2");
  end
  if (DEPTH < 2) begin : g_bad_depth
    $error("sram_2rw_param: DEPTH must be at least 2");
  end

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  function automatic logic [WIDTH-1:0] merge_w(
    input logic [WIDTH-1:0]  old_word,
    input logic [WIDTH-1:0]  new_word,
    input logic [MASK_W-1:0] mask
  );
    return WIDTH'(merge_bytes(MERGE_MAX_W'(old_word), MERGE_MAX_W'(new_word),
                              MERGE_MAX_MASK_W'(mask)));
  endfunction

  logic [WIDTH-1:0] mem [DEPTH];

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] init_cnt_q, init_cnt_d;
  logic              init_we;

  logic             p1_ok, p2_ok, same_addr;
  logic             p1_wr, p2_wr, p1_rd, p2_rd;
  logic [WIDTH-1:0] p1_old, p2_old, p1_base;
  logic [WIDTH-1:0] p1_wr_word, p2_wr_word;
  logic [WIDTH-1:0] p1_rd_word, p2_rd_word;

  assign ready = (state_q == ST_IDLE) && !reset;

  // Controller: clear sweep then permanent IDLE until the next reset
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    init_we    = 1'b0;
    if (state_q == ST_INIT && !reset) begin
      init_we    = 1'b1;
      init_cnt_d = init_cnt_q + 1'b1;
      if (init_cnt_q == LAST_ADDR) begin
        state_d    = ST_IDLE;
        init_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= (INIT_ZERO != 0) ? ST_INIT : ST_IDLE;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  // Request decode, write merge and collision resolution
  always_comb begin
    p1_ok     = ({1'b0, p1_addr} < DEPTH_EXT);
    p2_ok     = ({1'b0, p2_addr} < DEPTH_EXT);
    same_addr = (p1_addr == p2_addr);

    p1_wr = ready && p1_en && p1_we && p1_ok;
    p2_wr = ready && p2_en && p2_we && p2_ok;
    p1_rd = ready && p1_en && !p1_we;
    p2_rd = ready && p2_en && !p2_we;

    p1_old = p1_ok ? mem[p1_addr] : '0;
    p2_old = p2_ok ? mem[p2_addr] : '0;

    // Port 1 merges on top of port 2's result, so port 1 wins shared bytes
    // and the final array write from port 1 carries both contributions.
    p2_wr_word = merge_w(p2_old, p2_wdata, p2_wmask);
    p1_base    = (p2_wr && same_addr) ? p2_wr_word : p1_old;
    p1_wr_word = merge_w(p1_base, p1_wdata, p1_wmask);

    p1_rd_word = p1_old;
    p2_rd_word = p2_old;
    if (COLLIDE_MODE == COLLIDE_WRITE_FIRST) begin
      if (p2_wr && same_addr) p1_rd_word = p2_wr_word;
      if (p1_wr && same_addr) p2_rd_word = p1_wr_word;
    end
  end

  // Array update; port 1 is written last so its merged word takes effect on
  // a shared address.
  always_ff @(posedge clock) begin
    if (init_we) mem[init_cnt_q] <= '0;
    if (p2_wr)   mem[p2_addr]    <= p2_wr_word;
    if (p1_wr)   mem[p1_addr]    <= p1_wr_word;
  end

  sram_rd_pipe #(.WIDTH(WIDTH), .RD_LAT(RD_LAT)) u_rd_pipe_p1 (
    .clock    (clock),
    .reset    (reset),
    .req_vld  (p1_rd),
    .req_data (p1_rd_word),
    .rdata    (p1_rdata),
    .rvalid   (p1_rvalid)
  );

  sram_rd_pipe #(.WIDTH(WIDTH), .RD_LAT(RD_LAT)) u_rd_pipe_p2 (
    .clock    (clock),
    .reset    (reset),
    .req_vld  (p2_rd),
    .req_data (p2_rd_word),
    .rdata    (p2_rdata),
    .rvalid   (p2_rvalid)
  );

endmodule
